ddr5_request_queue: RTL and testbench

- Front-end stage directly upstream of the DDR5 command scheduler.
- Accepts timestamped CPU requests from the trace reader and releases each one only when the CPU cycle counter reaches its timestamp.
- Decodes the 34-bit address into the add_map fields and buffers requests in a bounded in-order queue.
- Presents the oldest entry to the scheduler through a valid/ready handshake, and generates the global done indication.

---
 rtl/ddr5_request_queue_pkg.sv | 76 +++++++
 rtl/ddr5_addr_map.sv | 21 ++
 rtl/ddr5_request_queue.sv | 116 +++++++++++
 tb/tb_ddr5_request_queue.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr5_request_queue_pkg.sv
// Shared declarations for the DDR5 request front end and scheduler: address map,
// queue entry layout, command/status encodings and address field positions.
package declarations0;

  localparam int DEFAULT_DEPTH = 16;
  localparam int ADDR_W        = 34;

  localparam int BYTE_SEL_LSB = 0;
  localparam int BYTE_SEL_W   = 2;
  localparam int COL_LOW_LSB  = 2;
  localparam int COL_LOW_W    = 4;
  localparam int CHANNEL_BIT  = 6;
  localparam int BG_LSB       = 7;
  localparam int BG_W         = 3;
  localparam int BANK_LSB     = 10;
  localparam int BANK_W       = 2;
  localparam int COL_HIGH_LSB = 12;
  localparam int COL_HIGH_W   = 6;
  localparam int ROW_LSB      = 18;
  localparam int ROW_W        = 16;

  typedef enum logic [1:0] {
    d_read = 2'd0,
    write  = 2'd1,
    i_read = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    NULL = 3'd0,
    ACT  = 3'd1,
    PRE  = 3'd2,
    RD   = 3'd3,
    WR   = 3'd4,
    REFR = 3'd5
  } commands;

  typedef enum logic [1:0] {
    not_started = 2'd0,
    in_flight   = 2'd1,
    completed   = 2'd2
  } state;

  typedef struct packed {
    logic [ROW_W-1:0]      row;
    logic [COL_HIGH_W-1:0] col_high;
    logic [BANK_W-1:0]     bank;
    logic [BG_W-1:0]       bank_group;
    logic                  channel;
    logic [COL_LOW_W-1:0]  col_low;
    logic [BYTE_SEL_W-1:0] byte_sel;
  } add_map;

  typedef struct packed {
    logic [15:0] t_rcd;
    logic [15:0] t_rp;
    logic [15:0] t_cl;
  } timing_t;

  typedef struct packed {
    add_map      mapped_add;
    op_e         operation;
    logic [63:0] cpu_cycles;
    commands     curr_cmd;
    commands     open_cmd;
    state        status;
    timing_t     tp;
  } queue_structure;

  // Only the fields that vary per request are held in the buffer.
  typedef struct packed {
    add_map      mapped_add;
    op_e         operation;
    logic [63:0] cpu_cycles;
  } slot_t;

endpackage

// File: rtl/ddr5_addr_map.sv
// Combinational 34-bit physical address to add_map decoder; also used by the
// scheduler's debug printer.
module ddr5_addr_map
  import declarations0::*;
(
  input  logic [ADDR_W-1:0] i_addr,
  output add_map            o_map
);

  always_comb begin
    o_map            = '0;
    o_map.byte_sel   = i_addr[BYTE_SEL_LSB +: BYTE_SEL_W];
    o_map.col_low    = i_addr[COL_LOW_LSB +: COL_LOW_W];
    o_map.channel    = i_addr[CHANNEL_BIT];
    o_map.bank_group = i_addr[BG_LSB +: BG_W];
    o_map.bank       = i_addr[BANK_LSB +: BANK_W];
    o_map.col_high   = i_addr[COL_HIGH_LSB +: COL_HIGH_W];
    o_map.row        = i_addr[ROW_LSB +: ROW_W];
  end

endmodule

// File: rtl/ddr5_request_queue.sv
// Timestamp-gated in-order request queue feeding the DDR5 command scheduler,
// with CPU cycle counter, illegal-op flag and sticky done indication.
module ddr5_request_queue
  import declarations0::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter bit FAST_FWD = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_cycles,
  input  logic [3:0]               in_core,
  input  logic [1:0]               in_op,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic                     trace_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output queue_structure           out_entry,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [63:0]              cycle_count,
  output logic                     err_illegal_op,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);

  slot_t           r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_occ;
  logic [63:0]     r_cycle;
  logic            r_err;
  logic            r_done;

  add_map          w_map;
  logic            w_full;
  logic            w_empty;
  logic            w_eligible;
  logic            w_take;
  logic            w_push;
  logic            w_pop;
  logic            w_unused_core;

  ddr5_addr_map u_addr_map (
    .i_addr (in_addr),
    .o_map  (w_map)
  );

  // Core id is not carried into the scheduler entry.
  assign w_unused_core = ^in_core;

  assign w_full     = (r_occ == (AW+1)'(DEPTH));
  assign w_empty    = (r_occ == '0);
  assign w_eligible = in_valid && (r_cycle >= in_cycles);
  assign in_ready   = !reset && w_eligible && !w_full;
  assign w_take     = in_valid && in_ready;
  assign w_push     = w_take && (in_op != 2'd3);
  assign out_valid  = !w_empty;
  assign w_pop      = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{mapped_add: w_map, operation: op_e'(in_op), cpu_cycles: in_cycles};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_cycle  <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase

      // Skip idle time only while nothing is buffered, so queued entries keep their order.
      if (FAST_FWD && w_empty && in_valid && (r_cycle < in_cycles)) begin
        r_cycle <= in_cycles;
      end else if (r_cycle != '1) begin
        r_cycle <= r_cycle + 64'd1;
      end

      r_err <= w_take && (in_op == 2'd3);

      if (trace_done && !in_valid && w_empty) r_done <= 1'b1;
    end
  end

  always_comb begin
    out_entry            = '0;
    out_entry.mapped_add = r_mem[r_rd_ptr].mapped_add;
    out_entry.operation  = r_mem[r_rd_ptr].operation;
    out_entry.cpu_cycles = r_mem[r_rd_ptr].cpu_cycles;
    out_entry.curr_cmd   = NULL;
    out_entry.open_cmd   = NULL;
    out_entry.status     = not_started;
    out_entry.tp         = '0;
  end

  assign occupancy      = r_occ;
  assign cycle_count    = r_cycle;
  assign err_illegal_op = r_err;
  assign done           = r_done;

endmodule

// File: tb/tb_ddr5_request_queue.sv
// Directed bench for ddr5_request_queue: timestamp gating, fast-forward, decode,
// full/backpressure with wrap, illegal op, done and mid-operation reset.
module tb_ddr5_request_queue;
  import declarations0::*;

  logic           clock;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [63:0]    in_cycles;
  logic [3:0]     in_core;
  logic [1:0]     in_op;
  logic [33:0]    in_addr;
  logic           trace_done;
  logic           out_valid;
  logic           out_ready;
  queue_structure out_entry;
  logic [4:0]     occupancy;
  logic [63:0]    cycle_count;
  logic           err_illegal_op;
  logic           done;

  logic           in_valid0;
  logic           in_ready0;
  logic [63:0]    in_cycles0;
  logic           out_valid0;
  queue_structure out_entry0;
  logic [4:0]     occupancy0;
  logic [63:0]    cycle_count0;
  logic           err_illegal_op0;
  logic           done0;

  int n_tests = 0;
  int n_fail  = 0;

  ddr5_request_queue #(.DEPTH(16), .FAST_FWD(1'b1)) u_dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_cycles      (in_cycles),
    .in_core        (in_core),
    .in_op          (in_op),
    .in_addr        (in_addr),
    .trace_done     (trace_done),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_entry      (out_entry),
    .occupancy      (occupancy),
    .cycle_count    (cycle_count),
    .err_illegal_op (err_illegal_op),
    .done           (done)
  );

  ddr5_request_queue #(.DEPTH(16), .FAST_FWD(1'b0)) u_dut_nofwd (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid0),
    .in_ready       (in_ready0),
    .in_cycles      (in_cycles0),
    .in_core        (4'd0),
    .in_op          (2'd0),
    .in_addr        (34'd0),
    .trace_done     (1'b0),
    .out_valid      (out_valid0),
    .out_ready      (1'b0),
    .out_entry      (out_entry0),
    .occupancy      (occupancy0),
    .cycle_count    (cycle_count0),
    .err_illegal_op (err_illegal_op0),
    .done           (done0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_cycles = '0; in_core = 4'd0; in_op = 2'd0;
    in_addr = '0; trace_done = 1'b0; out_ready = 1'b0; in_valid0 = 1'b0; in_cycles0 = '0;
    tick();
    in_valid = 1'b1; in_valid0 = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_in_ready0", in_ready0, 0);
    check("rst_occ", occupancy, 0);
    check("rst_cycle", cycle_count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err_illegal_op, 0);
    check("rst_done", done, 0);
    in_valid = 1'b0; in_valid0 = 1'b0;
    reset = 1'b0;

    // Timestamp gating without fast-forward
    in_valid0 = 1'b1; in_cycles0 = 64'd10;
    #1;
    for (int i = 0; i < 10; i++) begin
      check("gate_not_ready", in_ready0, 0);
      tick();
    end
    check("gate_cycle10", cycle_count0, 10);
    check("gate_ready", in_ready0, 1);
    tick();
    in_valid0 = 1'b0;
    check("gate_cycle11", cycle_count0, 11);
    check("gate_out_valid", out_valid0, 1);
    check("gate_map_zero", out_entry0.mapped_add, 0);
    check("gate_ts", out_entry0.cpu_cycles, 10);

    // Fast-forward
    do_reset();
    tick(); tick(); tick();
    check("ff_cycle3", cycle_count, 3);
    in_valid = 1'b1; in_cycles = 64'd1000; in_op = 2'd0; in_addr = '0;
    #1;
    check("ff_not_ready", in_ready, 0);
    tick();
    check("ff_cycle1000", cycle_count, 1000);
    check("ff_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; in_cycles = '0;
    check("ff_occ", occupancy, 1);
    check("ff_out_valid", out_valid, 1);
    check("ff_ts", out_entry.cpu_cycles, 1000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ff_drain", occupancy, 0);

    // Address decode
    in_valid = 1'b1; in_op = 2'd1; in_addr = 34'h3_FFFF_FFFF;
    tick();
    in_valid = 1'b0;
    check("dec_row", out_entry.mapped_add.row, 16'hFFFF);
    check("dec_col_high", out_entry.mapped_add.col_high, 6'h3F);
    check("dec_bank", out_entry.mapped_add.bank, 3);
    check("dec_bg", out_entry.mapped_add.bank_group, 7);
    check("dec_ch", out_entry.mapped_add.channel, 1);
    check("dec_col_low", out_entry.mapped_add.col_low, 4'hF);
    check("dec_byte", out_entry.mapped_add.byte_sel, 3);
    check("dec_op", out_entry.operation, 1);
    in_valid = 1'b1; in_op = 2'd2; in_addr = 34'h0_0000_0040; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("dec2_occ", occupancy, 1);
    check("dec2_ch", out_entry.mapped_add.channel, 1);
    check("dec2_map", out_entry.mapped_add, 34'h40);
    check("dec2_op", out_entry.operation, 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("dec2_drain", occupancy, 0);

    // Full / backpressure with pointer wrap
    in_op = 2'd0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_addr = 34'(k);
      #1;
      check("full_acc", in_ready, 1);
      tick();
    end
    in_addr = 34'd16;
    #1;
    check("full_occ16", occupancy, 16);
    check("full_blocked", in_ready, 0);
    check("full_head", out_entry.mapped_add, 0);
    out_ready = 1'b1;
    #1;
    check("full_blocked_pop", in_ready, 0);
    tick();
    out_ready = 1'b0;
    #1;
    check("full_occ15", occupancy, 15);
    check("full_ready_again", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("full_occ16b", occupancy, 16);
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      check("full_order", out_entry.mapped_add, 34'(k));
      tick();
    end
    out_ready = 1'b0;
    check("full_drained", occupancy, 0);

    // Illegal op with simultaneous pop, then legal push+pop
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_addr = 34'(100 + k);
      tick();
    end
    in_valid = 1'b0;
    check("ill_occ5", occupancy, 5);
    in_valid = 1'b1; in_op = 2'd3; in_addr = 34'd200; out_ready = 1'b1;
    #1;
    check("ill_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0; in_op = 2'd0;
    check("ill_occ4", occupancy, 4);
    check("ill_err", err_illegal_op, 1);
    tick();
    check("ill_err_clr", err_illegal_op, 0);
    in_valid = 1'b1; in_addr = 34'd300; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("pp_occ4", occupancy, 4);
    check("pp_head", out_entry.mapped_add, 102);

    // Done and reset
    trace_done = 1'b1;
    #1;
    check("done_early", done, 0);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    check("done_empty", occupancy, 0);
    check("done_not_yet", done, 0);
    tick();
    check("done_set", done, 1);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_addr = 34'(k);
      tick();
    end
    in_valid = 1'b0;
    check("done_sticky", done, 1);
    check("rst_mid_occ3", occupancy, 3);
    reset = 1'b1;
    tick();
    in_valid = 1'b1;
    #1;
    check("rst_mid_occ", occupancy, 0);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_in_ready", in_ready, 0);
    in_valid = 1'b0;
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
